// File: rtl/sdp_ram_arbiter_pkg.sv
// Shared types and helpers for the simple dual-port RAM arbiter.
// Vectors are sized for the largest legal requester count and narrowed by the callers.
package sdp_ram_arbiter_pkg;

    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned MAX_ID_W = 3;

    typedef logic [MAX_REQ-1:0]  req_vec_t;
    typedef logic [MAX_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    // First set request at or after ptr, wrapping modulo num_req.
    function automatic req_vec_t rr_grant(input req_vec_t req, input req_id_t ptr,
                                          input int unsigned num_req);
        req_vec_t    grant;
        logic        found;
        int unsigned idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = {29'd0, ptr} + i;
            if (idx >= num_req) idx = idx - num_req;
            if (!found && i < num_req && idx < MAX_REQ && req[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

    function automatic req_id_t onehot_to_idx(input req_vec_t onehot);
        req_id_t idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) idx = idx | i[MAX_ID_W-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdp_ram_arbiter_rr_arbiter.sv
// Round-robin arbiter with a combinational grant; the pointer moves past the winner
// on every advanced grant.
module rr_arbiter
    import sdp_ram_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic              advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] ptr;

    // Grant is held at zero while reset is asserted.
    always_comb begin
        grant = '0;
        if (rst_n) grant = NUM_REQ'(rr_grant(MAX_REQ'(valid), MAX_ID_W'(ptr), NUM_REQ));
        grant_idx = ID_W'(onehot_to_idx(MAX_REQ'(grant)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && |grant) begin
            ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Shares one simple dual-port RAM between NUM_REQ requesters: independent round-robin
// write and read arbiters, with read responses tagged back to the issuing requester.
module sdp_ram_arbiter
    import sdp_ram_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ          = 2,
    parameter  int unsigned DATA_WIDTH       = 8,
    parameter  int unsigned ADDR_WIDTH       = 8,
    parameter  string       IS_OUT_LATENCY   = "false",
    localparam int unsigned BYTE_VALID_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned REQ_ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [NUM_REQ-1:0]                   req_wr_valid_i,
    output logic [NUM_REQ-1:0]                   req_wr_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_wr_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wr_data_i,
    input  logic [NUM_REQ*BYTE_VALID_WIDTH-1:0]  req_wr_byte_valid_i,
    input  logic [NUM_REQ-1:0]                   req_rd_valid_i,
    output logic [NUM_REQ-1:0]                   req_rd_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_rd_addr_i,
    output logic [NUM_REQ-1:0]                   resp_valid_o,
    output logic [DATA_WIDTH-1:0]                resp_data_o,
    output logic                                 ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]                ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]                ram_wr_data_o,
    output logic [BYTE_VALID_WIDTH-1:0]          ram_wr_byte_valid_o,
    output logic                                 ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0]                ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]                ram_rd_data_i
);

    localparam int unsigned RD_LATENCY = (IS_OUT_LATENCY == "true") ? 2 : 1;

    logic [NUM_REQ-1:0]      wr_grant;
    logic [NUM_REQ-1:0]      rd_grant;
    logic [REQ_ID_WIDTH-1:0] wr_idx;
    logic [REQ_ID_WIDTH-1:0] rd_idx;
    logic                    wr_any;
    logic                    rd_any;
    tag_t                    tag0;
    tag_t                    resp_tag;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .valid     (req_wr_valid_i),
        .advance   (1'b1),
        .grant     (wr_grant),
        .grant_idx (wr_idx)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .valid     (req_rd_valid_i),
        .advance   (1'b1),
        .grant     (rd_grant),
        .grant_idx (rd_idx)
    );

    always_comb begin
        wr_any              = |wr_grant;
        req_wr_ready_o      = wr_grant;
        ram_wr_en_o         = wr_any;
        ram_wr_addr_o       = '0;
        ram_wr_data_o       = '0;
        ram_wr_byte_valid_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (wr_any && wr_idx == REQ_ID_WIDTH'(i)) begin
                ram_wr_addr_o       = req_wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                ram_wr_data_o       = req_wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                ram_wr_byte_valid_o = req_wr_byte_valid_i[i*BYTE_VALID_WIDTH +: BYTE_VALID_WIDTH];
            end
        end
    end

    // A cycle without a grant drives address 0, which also serves as the flush read.
    always_comb begin
        rd_any         = |rd_grant;
        req_rd_ready_o = rd_grant;
        ram_rd_addr_o  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rd_any && rd_idx == REQ_ID_WIDTH'(i)) begin
                ram_rd_addr_o = req_rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tag0 <= '0;
        end else begin
            tag0.valid <= rd_any;
            tag0.id    <= MAX_ID_W'(rd_idx);
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        tag_t tag1;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) tag1 <= '0;
            else          tag1 <= tag0;
        end

        // The RAM output register only advances on rd_en, so keep it high one extra cycle.
        always_comb begin
            resp_tag    = tag1;
            ram_rd_en_o = rd_any | tag0.valid;
        end
    end else begin : g_lat1
        always_comb begin
            resp_tag    = tag0;
            ram_rd_en_o = rd_any;
        end
    end

    always_comb begin
        resp_valid_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            resp_valid_o[i] = resp_tag.valid && (resp_tag.id == MAX_ID_W'(i));
        end
        resp_data_o = rst_n_i ? ram_rd_data_i : '0;
    end

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Drives two arbiters (1- and 2-cycle RAM latency) with identical stimulus and checks
// grants, RAM-side outputs and tagged responses against a reference model and scoreboard.
module tb_sdp_ram_arbiter;

    localparam int NR = 2;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [NR-1:0]    wr_valid, rd_valid;
    logic [NR*AW-1:0] wr_addr, rd_addr;
    logic [NR*DW-1:0] wr_data;
    logic [NR*BW-1:0] wr_bv;

    logic [NR-1:0] wr_ready [2];
    logic [NR-1:0] rd_ready [2];
    logic [NR-1:0] resp_valid [2];
    logic [DW-1:0] resp_data [2];
    logic          ram_wr_en [2];
    logic [AW-1:0] ram_wr_addr [2];
    logic [DW-1:0] ram_wr_data [2];
    logic [BW-1:0] ram_wr_bv [2];
    logic          ram_rd_en [2];
    logic [AW-1:0] ram_rd_addr [2];
    logic [DW-1:0] ram_rd_data [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdp_ram_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IS_OUT_LATENCY("false")
    ) u_dut_l1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_wr_valid_i(wr_valid), .req_wr_ready_o(wr_ready[0]),
        .req_wr_addr_i(wr_addr), .req_wr_data_i(wr_data), .req_wr_byte_valid_i(wr_bv),
        .req_rd_valid_i(rd_valid), .req_rd_ready_o(rd_ready[0]), .req_rd_addr_i(rd_addr),
        .resp_valid_o(resp_valid[0]), .resp_data_o(resp_data[0]),
        .ram_wr_en_o(ram_wr_en[0]), .ram_wr_addr_o(ram_wr_addr[0]),
        .ram_wr_data_o(ram_wr_data[0]), .ram_wr_byte_valid_o(ram_wr_bv[0]),
        .ram_rd_en_o(ram_rd_en[0]), .ram_rd_addr_o(ram_rd_addr[0]),
        .ram_rd_data_i(ram_rd_data[0])
    );

    sdp_ram_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IS_OUT_LATENCY("true")
    ) u_dut_l2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_wr_valid_i(wr_valid), .req_wr_ready_o(wr_ready[1]),
        .req_wr_addr_i(wr_addr), .req_wr_data_i(wr_data), .req_wr_byte_valid_i(wr_bv),
        .req_rd_valid_i(rd_valid), .req_rd_ready_o(rd_ready[1]), .req_rd_addr_i(rd_addr),
        .resp_valid_o(resp_valid[1]), .resp_data_o(resp_data[1]),
        .ram_wr_en_o(ram_wr_en[1]), .ram_wr_addr_o(ram_wr_addr[1]),
        .ram_wr_data_o(ram_wr_data[1]), .ram_wr_byte_valid_o(ram_wr_bv[1]),
        .ram_rd_en_o(ram_rd_en[1]), .ram_rd_addr_o(ram_rd_addr[1]),
        .ram_rd_data_i(ram_rd_data[1])
    );

    // Behavioural RAMs: read-first, byte-enabled writes; the second has an output register.
    bit [DW-1:0] mem [2][256];
    bit [DW-1:0] stage;
    bit [DW-1:0] word;

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ram_wr_en[g]) begin
                word = mem[g][ram_wr_addr[g]];
                for (int b = 0; b < BW; b++)
                    if (ram_wr_bv[g][b]) word[b*8 +: 8] = ram_wr_data[g][b*8 +: 8];
                mem[g][ram_wr_addr[g]] <= word;
            end
        end
        if (ram_rd_en[0]) ram_rd_data[0] <= mem[0][ram_rd_addr[0]];
        if (ram_rd_en[1]) begin
            stage          <= mem[1][ram_rd_addr[1]];
            ram_rd_data[1] <= stage;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int i = (ptr + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    typedef struct {
        int          dut;
        int          due;
        int          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        sb[$];
    bit [DW-1:0] ref_mem [256];
    int          m_wptr, m_rptr, gw, gr, k;
    bit          m_prev_rd, hit;
    logic [NR-1:0] e_wready, e_rready, e_resp;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [DW-1:0] e_wdata, e_rdata, rd_old;
    logic [BW-1:0] e_wbv;
    logic          e_ren;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("rst_wr_ready%0d", d), 32'(wr_ready[d]), 0);
                check($sformatf("rst_rd_ready%0d", d), 32'(rd_ready[d]), 0);
                check($sformatf("rst_resp_valid%0d", d), 32'(resp_valid[d]), 0);
                check($sformatf("rst_wr_en%0d", d), 32'(ram_wr_en[d]), 0);
                check($sformatf("rst_rd_en%0d", d), 32'(ram_rd_en[d]), 0);
                check($sformatf("rst_rd_addr%0d", d), 32'(ram_rd_addr[d]), 0);
            end
            m_wptr = 0; m_rptr = 0; m_prev_rd = 1'b0;
            sb.delete();
        end else begin
            gw = pick(wr_valid, m_wptr);
            gr = pick(rd_valid, m_rptr);
            e_wready = '0; e_rready = '0; e_waddr = '0; e_wdata = '0; e_wbv = '0; e_raddr = '0;
            if (gw >= 0) begin
                e_wready[gw] = 1'b1;
                e_waddr = wr_addr[gw*AW +: AW];
                e_wdata = wr_data[gw*DW +: DW];
                e_wbv   = wr_bv[gw*BW +: BW];
            end
            if (gr >= 0) begin
                e_rready[gr] = 1'b1;
                e_raddr = rd_addr[gr*AW +: AW];
            end
            for (int d = 0; d < 2; d++) begin
                check($sformatf("wr_ready%0d", d), 32'(wr_ready[d]), 32'(e_wready));
                check($sformatf("wr_en%0d", d), 32'(ram_wr_en[d]), 32'(gw >= 0));
                check($sformatf("wr_addr%0d", d), 32'(ram_wr_addr[d]), 32'(e_waddr));
                check($sformatf("wr_data%0d", d), 32'(ram_wr_data[d]), 32'(e_wdata));
                check($sformatf("wr_bv%0d", d), 32'(ram_wr_bv[d]), 32'(e_wbv));
                check($sformatf("rd_ready%0d", d), 32'(rd_ready[d]), 32'(e_rready));
                e_ren = (gr >= 0) || (d == 1 && m_prev_rd);
                check($sformatf("rd_en%0d", d), 32'(ram_rd_en[d]), 32'(e_ren));
                check($sformatf("rd_addr%0d", d), 32'(ram_rd_addr[d]), 32'(e_raddr));
                k = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (sb[i].dut == d) begin k = i; break; end
                e_resp = '0; e_rdata = '0; hit = 1'b0;
                if (k >= 0 && sb[k].due == cyc) begin
                    e_resp[sb[k].id] = 1'b1;
                    e_rdata = sb[k].data;
                    hit = 1'b1;
                    sb.delete(k);
                end
                check($sformatf("resp_valid%0d", d), 32'(resp_valid[d]), 32'(e_resp));
                if (hit) check($sformatf("resp_data%0d", d), 32'(resp_data[d]), 32'(e_rdata));
            end
            if (gr >= 0) begin
                rd_old = ref_mem[e_raddr];
                sb.push_back('{dut: 0, due: cyc + 1, id: gr, data: rd_old});
                sb.push_back('{dut: 1, due: cyc + 2, id: gr, data: rd_old});
                m_rptr = (gr + 1) % NR;
            end
            if (gw >= 0) begin
                for (int b = 0; b < BW; b++)
                    if (e_wbv[b]) ref_mem[e_waddr][b*8 +: 8] = e_wdata[b*8 +: 8];
                m_wptr = (gw + 1) % NR;
            end
            m_prev_rd = (gr >= 0);
        end
    end

    task automatic idle();
        wr_valid = '0;
        rd_valid = '0;
    endtask

    task automatic set_wr(input int r, input logic [AW-1:0] a, input logic [DW-1:0] dt,
                          input logic [BW-1:0] bv);
        wr_valid[r]         = 1'b1;
        wr_addr[r*AW +: AW] = a;
        wr_data[r*DW +: DW] = dt;
        wr_bv[r*BW +: BW]   = bv;
    endtask

    task automatic set_rd(input int r, input logic [AW-1:0] a);
        rd_valid[r]         = 1'b1;
        rd_addr[r*AW +: AW] = a;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            idle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_addr = '0; wr_data = '0; wr_bv = '0; rd_addr = '0;
        idle();
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Write then tagged read-back by the other requester.
        set_wr(0, 8'h10, 16'h00A5, 2'b11); tick();
        set_rd(1, 8'h10); tick();
        tick(3);

        // Both requesters reading continuously alternate grants.
        set_wr(0, 8'h01, 16'h1111, 2'b11); tick();
        set_wr(0, 8'h02, 16'h2222, 2'b11); tick();
        repeat (6) begin set_rd(0, 8'h01); set_rd(1, 8'h02); tick(); end
        tick(3);

        // Both requesters writing continuously alternate grants; read back.
        repeat (4) begin
            set_wr(0, 8'h40, 16'h0101, 2'b11); set_wr(1, 8'h41, 16'h0202, 2'b11); tick();
        end
        set_rd(0, 8'h40); tick();
        set_rd(0, 8'h41); tick();
        tick(3);

        // Isolated read: flush cycle on the 2-cycle instance, no extra response.
        set_wr(1, 8'h05, 16'h003C, 2'b11); tick();
        tick(2);
        set_rd(0, 8'h05); tick();
        tick(4);

        // Same-cycle write/read returns old data; next read returns new data.
        set_wr(0, 8'h20, 16'h0011, 2'b11); tick();
        set_wr(0, 8'h20, 16'h0077, 2'b11); set_rd(1, 8'h20); tick();
        set_rd(1, 8'h20); tick();
        tick(3);

        // Partial byte write.
        set_wr(1, 8'h30, 16'h1234, 2'b11); tick();
        set_wr(1, 8'h30, 16'hBEEF, 2'b10); tick();
        set_rd(0, 8'h30); tick();
        tick(3);

        // Single requester held continuously, then an address change while waiting.
        repeat (4) begin set_rd(1, 8'h30); tick(); end
        set_rd(0, 8'h01); set_rd(1, 8'h02); tick();
        set_rd(1, 8'h20); tick();
        tick(3);

        // Reset with reads in flight and both pointers moved off zero.
        set_rd(1, 8'h01); tick();
        set_rd(0, 8'h02); set_wr(0, 8'h50, 16'h5555, 2'b11); tick();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        set_rd(0, 8'h40); set_rd(1, 8'h41);
        set_wr(0, 8'h60, 16'h6060, 2'b11); set_wr(1, 8'h61, 16'h6161, 2'b11);
        tick();
        tick(4);

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
